// File: rtl/dma_stream_loader.sv
// Loads one DMA stream frame into a MEM_DEPTH-1 word buffer; arm-triggered, flags short/long frames.
// Latency: write strobe one cycle after each handshake; tready held low outside LOAD/DRAIN.
module dma_stream_loader #(
    parameter int MEM_DEPTH  = 5,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [63:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [63:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 2);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic                    tready_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [63:0]             wr_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    frame_err_q;
    logic                    hs;

    // tready is registered, so the handshake uses the value the stream sees this cycle.
    always_comb begin
        hs    = s_axis_tvalid & tready_q;
        cnt_d = cnt_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tready_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        frame_err_q <= 1'b0;
                        tready_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q;
                        wr_data_q <= s_axis_tdata;
                        if (cnt_q == LAST_ADDR) begin
                            // Buffer full: a missing tlast means the rest of the frame is drained.
                            if (s_axis_tlast) begin
                                state_q  <= DONE;
                                tready_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                state_q     <= DRAIN;
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                            if (s_axis_tlast) begin
                                state_q     <= DONE;
                                tready_q    <= 1'b0;
                                done_q      <= 1'b1;
                                frame_err_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (hs && s_axis_tlast) begin
                        state_q  <= DONE;
                        tready_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_dma_stream_loader.sv
// Bench for dma_stream_loader: directed and random frames checked against a frame-level model.
module tb_dma_stream_loader;
    localparam int MD = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          busy;
    logic          done;
    logic          frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] mon_addr[$];
    logic [63:0]   mon_data[$];
    int            mon_cyc[$];
    int            done_cnt;
    int            done_cyc;
    logic [63:0]   sent[$];
    int            last_hs;

    dma_stream_loader #(.MEM_DEPTH(MD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
            mon_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_clears_err", 64'(frame_err), 64'd0);
        check("arm_busy", 64'(busy), 64'd1);
    endtask

    // Presents one beat and holds it until accepted (bounded wait).
    task automatic send_beat(input logic [63:0] d, input bit last, input bit arm_now);
        bit got;
        got = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        arm           = arm_now;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                got     = 1'b1;
                last_hs = cyc;
            end
            @(posedge clk);
            #1;
            arm = 1'b0;
        end
        check("beat_accepted", 64'(got), 64'd1);
        sent.push_back(d);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gap_lo, input int gap_hi, input bit arm_mid);
        sent.delete();
        clear_mon();
        do_arm();
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gap_hi, gap_lo);
            repeat (g) tick();
            send_beat({$urandom, $urandom}, (i == n - 1), arm_mid && (i == 1));
        end
        for (int k = 0; k < 6 && busy; k++) tick();
        tick();
    endtask

    // Frame model: the first MD-1 beats land at addresses 0.., the rest are dropped;
    // any length other than MD-1 is an error; done fires once, one cycle after the last handshake.
    task automatic verify(input int n, input bit gapless);
        int nexp;
        int nchk;
        nexp = (n < MD - 1) ? n : MD - 1;
        check("wr_count", 64'(mon_addr.size()), 64'(nexp));
        nchk = (mon_addr.size() < nexp) ? mon_addr.size() : nexp;
        for (int i = 0; i < nchk; i++) begin
            check("wr_addr", 64'(mon_addr[i]), 64'(i));
            check("wr_data", mon_data[i], sent[i]);
        end
        check("frame_err", 64'(frame_err), 64'(n != MD - 1));
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_latency", 64'(done_cyc), 64'(last_hs + 1));
        check("busy_after", 64'(busy), 64'd0);
        check("tready_idle", 64'(s_axis_tready), 64'd0);
        if (nchk == nexp && nexp > 0) begin
            if (n <= MD - 1)
                check("last_wr_at_done", 64'(mon_cyc[nexp-1]), 64'(done_cyc));
            if (gapless)
                check("wr_consecutive", 64'(mon_cyc[nexp-1] - mon_cyc[0]), 64'(nexp - 1));
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tready"}, 64'(s_axis_tready), 64'd0);
        check({pfx, "_wr_en"}, 64'(wr_en), 64'd0);
        check({pfx, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({pfx, "_wr_data"}, wr_data, 64'd0);
        check({pfx, "_busy"}, 64'(busy), 64'd0);
        check({pfx, "_done"}, 64'(done), 64'd0);
        check({pfx, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        arm           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_mon();
        repeat (3) tick();
        check_reset_outputs("rst");
        arm   = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Nominal frame, continuous
        send_frame(4, 0, 0, 1'b0);
        verify(4, 1'b1);
        // Same frame with 2-cycle gaps
        send_frame(4, 2, 2, 1'b0);
        verify(4, 1'b0);
        // Short frame
        send_frame(2, 0, 0, 1'b0);
        verify(2, 1'b1);
        repeat (3) tick();
        check("err_sticky", 64'(frame_err), 64'd1);
        // Long frame drained
        send_frame(6, 0, 0, 1'b0);
        verify(6, 1'b1);
        // Single-beat frame
        send_frame(1, 0, 0, 1'b0);
        verify(1, 1'b1);
        // arm pulsed during LOAD is ignored
        send_frame(4, 0, 1, 1'b1);
        verify(4, 1'b0);

        // Reset after the second handshake abandons the frame
        sent.delete();
        clear_mon();
        do_arm();
        send_beat(64'h11, 1'b0, 1'b0);
        send_beat(64'h22, 1'b0, 1'b0);
        rst_n = 1'b0;
        arm   = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        arm   = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (5) tick();
        s_axis_tvalid = 1'b0;
        check("midrst_writes", 64'(mon_addr.size()), 64'd2);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        send_frame(4, 0, 0, 1'b0);
        verify(4, 1'b1);

        // Random frames
        for (int r = 0; r < 16; r++) begin
            int n;
            int gh;
            n  = $urandom_range(7, 1);
            gh = $urandom_range(2, 0);
            send_frame(n, 0, gh, 1'($urandom_range(1, 0)));
            verify(n, gh == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_stream_loader.md
DMA_STREAM_LOADER -- requirements
Module: dma_stream_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 5, downstream buffer depth; the loader SHALL write MEM_DEPTH-1 data words per frame, addresses 0..MEM_DEPTH-2.
REQ-002 Parameter ADDR_WIDTH, default 3, width of wr_addr.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 arm  in  1  single-cycle request to accept one frame.
REQ-006 s_axis_tdata  in  64  DMA stream data.
REQ-007 s_axis_tvalid  in  1  stream data valid.
REQ-008 s_axis_tlast  in  1  last beat of frame.
REQ-009 s_axis_tready  out  1  loader ready for a beat.
REQ-010 wr_en  out  1  buffer write strobe; drives buffer start.
REQ-011 wr_addr  out  ADDR_WIDTH  buffer write address; drives buffer in_addr.
REQ-012 wr_data  out  64  buffer write data; drives buffer din.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 done  out  1  one-cycle pulse at frame end.
REQ-015 frame_err  out  1  sticky frame-length error, cleared by the next accepted arm.

Function
REQ-016 States SHALL be IDLE, LOAD, DRAIN, DONE; state, word counter and all outputs SHALL be registered.
REQ-017 IDLE: s_axis_tready=0; arm SHALL move to LOAD, clear counter to 0, clear frame_err.
REQ-018 arm outside IDLE SHALL be ignored.
REQ-019 Handshake = s_axis_tvalid & s_axis_tready in the same cycle; only handshakes SHALL advance the counter.
REQ-020 LOAD: s_axis_tready=1; each handshake SHALL produce, next cycle, wr_en=1, wr_addr=counter, wr_data=s_axis_tdata; counter SHALL then increment.
REQ-021 wr_en SHALL be 0 in any cycle not following a LOAD handshake; wr_addr/wr_data SHALL hold their last values when wr_en=0.
REQ-022 Handshake with counter=MEM_DEPTH-2 and tlast=1: go to DONE, frame_err stays 0.
REQ-023 Handshake with counter=MEM_DEPTH-2 and tlast=0 (long frame): word written, frame_err=1, go to DRAIN.
REQ-024 Handshake with counter<MEM_DEPTH-2 and tlast=1 (short frame): word written, frame_err=1, go to DONE.
REQ-025 DRAIN: s_axis_tready=1, beats discarded (wr_en=0); handshake with tlast=1 SHALL go to DONE.
REQ-026 DONE: s_axis_tready=0, done=1 for exactly one cycle, then IDLE.
REQ-027 Counter SHALL never exceed MEM_DEPTH-2 and SHALL not wrap.
REQ-028 tvalid gaps SHALL stall without state change; throughput SHALL be one word per cycle when tvalid is continuous.
REQ-029 Latency: last write strobe and transition to DONE occur in the same cycle, one cycle after the final handshake; done asserts that cycle.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, counter=0, s_axis_tready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0, overriding all other inputs including arm.
REQ-031 Reset mid-frame SHALL abandon the frame; no further wr_en until a new arm after reset release.

Verification
REQ-032 arm, then 4 beats 0xA0..0xA3 continuous, tlast on 4th -> wr_en at addr 0,1,2,3 with matching data on consecutive cycles, done pulse once, frame_err=0.
REQ-033 Same frame with tvalid deasserted 2 cycles between beats -> identical writes, no extra wr_en, no state change during gaps.
REQ-034 arm, 2 beats, tlast on 2nd -> writes addr 0,1 only, frame_err=1, done pulse, busy=0 after.
REQ-035 arm, 6 beats, tlast on 6th -> writes addr 0..3 only, beats 5-6 consumed with tready=1 and wr_en=0, frame_err=1, done after 6th.
REQ-036 rst_n=0 after 2nd handshake -> all outputs at reset values next cycle; subsequent arm with 4-beat good frame writes addr 0..3, frame_err=0.
REQ-037 arm pulsed during LOAD -> ignored; counter and frame_err unchanged.
